// File: rtl/perm_check.sv
// rtl/perm_check.sv - read-only permutation / duplicate checker for the ARC4 S memory
//
// Scans every S memory location through the memory's read port and reports
// whether the contents are a permutation of 0..2**ADDR_W-1, plus the first
// repeated value and where it was found. Never writes the memory.
//
// Optional feature: define PERM_CHECK_IDENTITY_EN to also check S[i]==i
// (ident_ok); when undefined ident_ok is tied to 0.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   en         start request, accepted only while rdy=1
//   rdy        1 = idle / results valid, 0 = scan in progress
//   addr       read address to S memory
//   rddata     S memory read data, valid one cycle after addr is registered
//   pass       last scan found N distinct values
//   dup_found  last scan saw a repeated value
//   dup_addr   address of first repeat (0 if none)
//   dup_val    value of first repeat (0 if none)
//   ident_ok   S[i]==i for all i (identity option only)

module perm_check #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] rddata,
  output logic              pass,
  output logic              dup_found,
  output logic [ADDR_W-1:0] dup_addr,
  output logic [ADDR_W-1:0] dup_val,
  output logic              ident_ok
);

  localparam int N = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state;
  logic [N-1:0]      seen;
  // smp_v/smp_a track the address issued one edge earlier; together with the
  // RAM's own address register this lines rddata up with smp_a.
  logic              smp_v;
  logic [ADDR_W-1:0] smp_a;
  logic              new_dup;

  assign new_dup = smp_v && seen[rddata] && !dup_found;

`ifdef PERM_CHECK_IDENTITY_EN
  logic ident_flag;
  logic ident_clr;
  assign ident_clr = smp_v && (rddata != smp_a);
`else
  assign ident_ok = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      addr      <= '0;
      seen      <= '0;
      smp_v     <= 1'b0;
      smp_a     <= '0;
      pass      <= 1'b0;
      dup_found <= 1'b0;
      dup_addr  <= '0;
      dup_val   <= '0;
`ifdef PERM_CHECK_IDENTITY_EN
      ident_flag <= 1'b0;
      ident_ok   <= 1'b0;
`endif
    end else begin
      smp_v <= 1'b0;

      if (smp_v) begin
        seen[rddata] <= 1'b1;
        if (new_dup) begin
          dup_found <= 1'b1;
          dup_addr  <= smp_a;
          dup_val   <= rddata;
        end
`ifdef PERM_CHECK_IDENTITY_EN
        if (ident_clr) ident_flag <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (en) begin
            state     <= READ;
            rdy       <= 1'b0;
            addr      <= '0;
            seen      <= '0;
            pass      <= 1'b0;
            dup_found <= 1'b0;
            dup_addr  <= '0;
            dup_val   <= '0;
`ifdef PERM_CHECK_IDENTITY_EN
            ident_flag <= 1'b1;
            ident_ok   <= 1'b0;
`endif
          end
        end
        READ: begin
          smp_v <= 1'b1;
          smp_a <= addr;
          // Hold at the last address rather than wrapping.
          if (addr == {ADDR_W{1'b1}}) state <= DRAIN;
          else                        addr  <= addr + ADDR_W'(1);
        end
        DRAIN: begin
          // The final sample (address N-1) lands on this edge.
          state <= IDLE;
          rdy   <= 1'b1;
          pass  <= !(dup_found || new_dup);
`ifdef PERM_CHECK_IDENTITY_EN
          ident_ok <= ident_flag && !ident_clr;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
